systolic_writeback: RTL and testbench

SYSTOLIC_WRITEBACK -- requirements
Module: systolic_writeback

---
 rtl/systolic_writeback.sv | 131 +++++++++++++
 tb/tb_systolic_writeback.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_writeback.sv
// Requantizes systolic-array row results to signed bytes and writes
// each row as two SRAM words, one row per cycle, ARRAY_SIZE rows per tile.
module systolic_writeback #(
  parameter int ARRAY_SIZE      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10
) (
  input  logic                                  clk,
  input  logic                                  srstn,
  input  logic                                  start,
  input  logic [ADDR_WIDTH-1:0]                 base_addr,
  input  logic [4:0]                            shift_amt,
  input  logic [ARRAY_SIZE*(2*DATA_WIDTH+5)-1:0] mul_outcome,
  input  logic                                  outcome_valid,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  sram_wen,
  output logic [ADDR_WIDTH-1:0]                 sram_waddr,
  output logic [SRAM_DATA_WIDTH-1:0]            sram_wdata0,
  output logic [SRAM_DATA_WIDTH-1:0]            sram_wdata1,
  output logic [7:0]                            sat_count
);

  localparam int LW   = 2*DATA_WIDTH+5;
  localparam int LPB  = SRAM_DATA_WIDTH/DATA_WIDTH;
  localparam int CW   = $clog2(ARRAY_SIZE);
  localparam int NW   = $clog2(ARRAY_SIZE+1);
  localparam int QMAXI = 2**(DATA_WIDTH-1)-1;
  localparam int QMINI = -(2**(DATA_WIDTH-1));
  localparam logic signed [LW:0] QMAX = QMAXI[LW:0];
  localparam logic signed [LW:0] QMIN = QMINI[LW:0];

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         row_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [4:0]            shift_q;

  logic [DATA_WIDTH-1:0] q [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0] clip;
  logic [NW-1:0]         nclip;
  logic [SRAM_DATA_WIDTH-1:0] w0, w1;
  logic [8:0]            sat_sum;
  logic [7:0]            sat_nx;
  logic                  accept, capture, last;

  assign busy    = (state != IDLE);
  assign accept  = (state == IDLE) && start;
  assign capture = (state == COLLECT) && outcome_valid;
  assign last    = (row_cnt == CW'(ARRAY_SIZE-1));

  // Round half up, arithmetic shift in LW+1 bits, then clamp
  always_comb begin
    logic signed [LW:0] xe, rnd, y;
    xe = '0;
    rnd = '0;
    y = '0;
    clip = '0;
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      xe = {mul_outcome[k*LW+LW-1], mul_outcome[k*LW +: LW]};
      rnd = (shift_q == 5'd0) ? '0
          : ((LW+1)'(1) << (shift_q - 5'd1));
      y = (xe + rnd) >>> shift_q;
      clip[k] = (y > QMAX) || (y < QMIN);
      if (y > QMAX)
        q[k] = QMAX[DATA_WIDTH-1:0];
      else if (y < QMIN)
        q[k] = QMIN[DATA_WIDTH-1:0];
      else
        q[k] = y[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    w0 = '0;
    w1 = '0;
    nclip = '0;
    for (int j = 0; j < LPB; j++) begin
      w0[SRAM_DATA_WIDTH-1-DATA_WIDTH*j -: DATA_WIDTH] = q[j];
      w1[SRAM_DATA_WIDTH-1-DATA_WIDTH*j -: DATA_WIDTH] = q[LPB+j];
    end
    for (int k = 0; k < ARRAY_SIZE; k++)
      nclip = nclip + NW'(clip[k]);
    sat_sum = {1'b0, sat_count} + 9'(nclip);
    sat_nx = sat_sum[8] ? 8'hFF : sat_sum[7:0];
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state       <= IDLE;
      row_cnt     <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      done        <= 1'b0;
      sram_wen    <= 1'b1;
      sram_waddr  <= '0;
      sram_wdata0 <= '0;
      sram_wdata1 <= '0;
      sat_count   <= '0;
    end else begin
      done     <= 1'b0;
      sram_wen <= 1'b1;
      if (accept) begin
        state     <= COLLECT;
        row_cnt   <= '0;
        addr_q    <= base_addr;
        shift_q   <= (shift_amt > 5'd20) ? 5'd20 : shift_amt;
        sat_count <= '0;
      end else if (capture) begin
        sram_wen    <= 1'b0;
        sram_waddr  <= addr_q;
        sram_wdata0 <= w0;
        sram_wdata1 <= w1;
        sat_count   <= sat_nx;
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        row_cnt     <= row_cnt + CW'(1);
        if (last) begin
          state <= FLUSH;
          done  <= 1'b1;
        end
      end else if (state == FLUSH) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_systolic_writeback.sv
// Randomized scoreboard bench for systolic_writeback with a
// plain-arithmetic requantization model.
module tb_systolic_writeback;

  logic         clk;
  logic         srstn;
  logic         start;
  logic [9:0]   base_addr;
  logic [4:0]   shift_amt;
  logic [167:0] mul_outcome;
  logic         outcome_valid;
  logic         busy, done, sram_wen;
  logic [9:0]   sram_waddr;
  logic [31:0]  sram_wdata0, sram_wdata1;
  logic [7:0]   sat_count;

  systolic_writeback dut (
    .clk(clk), .srstn(srstn), .start(start),
    .base_addr(base_addr), .shift_amt(shift_amt),
    .mul_outcome(mul_outcome), .outcome_valid(outcome_valid),
    .busy(busy), .done(done), .sram_wen(sram_wen),
    .sram_waddr(sram_waddr), .sram_wdata0(sram_wdata0),
    .sram_wdata1(sram_wdata1), .sat_count(sat_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          last;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 0;
  bit          m_busy = 0;
  int          m_rows = 0;
  int          m_shift = 0;
  logic [9:0]  m_addr = '0;
  int          m_sat = 0;
  logic [31:0] last_w0 = '0;
  logic [31:0] last_w1 = '0;
  int          lanes[8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int quant(input int x, input int s, output bit clipped);
    longint n, d, y;
    if (s > 20) s = 20;
    if (s == 0) y = x;
    else begin
      d = longint'(1) << s;
      n = x + d / 2;
      y = (n >= 0) ? n / d : -((-n + d - 1) / d);
    end
    clipped = (y > 127) || (y < -128);
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return int'(y);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sram_wen === 1'b0) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h got a write, expected none", sram_waddr);
        end else begin
          e = sbq.pop_front();
          chk("waddr", sram_waddr, e.addr);
          chk("wdata0", sram_wdata0, e.w0);
          chk("wdata1", sram_wdata1, e.w1);
          chk("done_on_write", done, e.last);
          last_w0 = e.w0;
          last_w1 = e.w1;
        end
      end else begin
        chk("done_idle", done, 0);
        chk("hold_wdata0", sram_wdata0, last_w0);
        chk("hold_wdata1", sram_wdata1, last_w1);
      end
    end
  end

  task automatic do_start(input logic [9:0] b, input logic [4:0] s);
    start = 1;
    base_addr = b;
    shift_amt = s;
    if (!m_busy) begin
      m_busy = 1;
      m_rows = 0;
      m_addr = b;
      m_shift = s;
      m_sat = 0;
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_row(input bit v);
    exp_t e;
    logic [7:0] by[8];
    int nclip;
    bit c;
    for (int k = 0; k < 8; k++) mul_outcome[21*k +: 21] = lanes[k][20:0];
    outcome_valid = v;
    if (v && m_busy && m_rows < 8) begin
      nclip = 0;
      for (int k = 0; k < 8; k++) begin
        by[k] = 8'(quant(lanes[k], m_shift, c));
        nclip += int'(c);
      end
      e.addr = m_addr;
      e.w0 = {by[0], by[1], by[2], by[3]};
      e.w1 = {by[4], by[5], by[6], by[7]};
      m_addr = m_addr + 10'd1;
      m_rows++;
      e.last = (m_rows == 8);
      m_sat = (m_sat + nclip > 255) ? 255 : m_sat + nclip;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    outcome_valid = 0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL busy_timeout: busy still %0b, expected 0", busy);
    end
    m_busy = 0;
    chk("queue_empty", sbq.size(), 0);
    chk("sat_count", sat_count, m_sat);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("sat_hold", sat_count, m_sat);
  endtask

  task automatic rand_lanes();
    int v;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = int'($urandom);
        lanes[k] = (v <<< 11) >>> 11;
      end else begin
        lanes[k] = int'($urandom_range(0, 600)) - 300;
      end
    end
  endtask

  task automatic reset_checks();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wen", sram_wen, 1);
    chk("rst_waddr", sram_waddr, 0);
    chk("rst_wdata0", sram_wdata0, 0);
    chk("rst_wdata1", sram_wdata1, 0);
    chk("rst_sat", sat_count, 0);
  endtask

  task automatic apply_reset();
    srstn = 0;
    sbq.delete();
    last_w0 = '0;
    last_w1 = '0;
    m_busy = 0;
    m_rows = 0;
    m_sat = 0;
    #1;
    reset_checks();
  endtask

  initial begin
    srstn = 1;
    start = 0;
    base_addr = '0;
    shift_amt = '0;
    mul_outcome = '0;
    outcome_valid = 0;
    #2;
    apply_reset();
    mon_en = 1;
    @(posedge clk); #1;
    srstn = 1;
    @(posedge clk); #1;

    // lane k = k, unshifted
    do_start(10'h010, 5'd0);
    for (int k = 0; k < 8; k++) lanes[k] = k;
    repeat (8) send_row(1);
    wait_done();

    // rounding and arithmetic shift
    do_start(10'h100, 5'd4);
    lanes[0] = 24; lanes[1] = -24; lanes[2] = 8; lanes[3] = 7;
    for (int k = 4; k < 8; k++) lanes[k] = -k * 9;
    repeat (8) send_row(1);
    wait_done();

    // clamping, two clipped lanes per row
    do_start(10'h200, 5'd0);
    lanes[0] = 300; lanes[1] = -1000;
    for (int k = 2; k < 8; k++) lanes[k] = 5;
    repeat (8) send_row(1);
    wait_done();

    // address wrap
    do_start(10'h3FE, 5'd1);
    repeat (8) begin
      rand_lanes();
      send_row(1);
    end
    wait_done();

    // idle rows ignored, gaps, start mid-tile ignored, row in FLUSH ignored
    rand_lanes();
    send_row(1);
    do_start(10'h050, 5'd2);
    for (int r = 0; r < 8; r++) begin
      rand_lanes();
      send_row(1);
      if (r == 2) do_start(10'h2AA, 5'd7);
      if (r % 3 == 1) send_row(0);
    end
    rand_lanes();
    send_row(1);
    wait_done();

    // reset mid-tile after 3 rows
    do_start(10'h120, 5'd3);
    repeat (3) begin
      rand_lanes();
      send_row(1);
    end
    @(negedge clk); #2;
    apply_reset();
    rand_lanes();
    send_row(1);
    @(posedge clk); #1;
    srstn = 1;
    rand_lanes();
    send_row(1);
    chk("post_rst_busy", busy, 0);
    do_start(10'h0C0, 5'd5);
    repeat (8) begin
      rand_lanes();
      send_row(1);
    end
    wait_done();

    // randomized tiles
    for (int t = 0; t < 25; t++) begin
      do_start(10'($urandom), 5'($urandom));
      while (m_rows < 8) begin
        rand_lanes();
        if ($urandom_range(0, 3) == 0) send_row(0);
        else send_row(1);
        if (m_rows < 8 && $urandom_range(0, 9) == 0)
          do_start(10'($urandom), 5'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        rand_lanes();
        send_row(1);
      end
      wait_done();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
